// File: rtl/sw_axis.sv
// Debounced 8-bit switch-bank source: each accepted change of the switch bank
// becomes one AXI-stream beat, queued in a small show-ahead FIFO.
module sw_axis #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       axis_aclk_i,
    input  logic       axis_aresetn_i,
    input  logic [7:0] sw_i,
    input  logic       m_axis_tready_i,
    output logic       m_axis_tvalid_o,
    output logic [7:0] m_axis_tdata_o,
    output logic       overflow_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_stable;
    logic [7:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;
    logic             r_tvalid;
    logic [7:0]       r_tdata;
    logic             r_overflow;

    logic             w_commit;
    logic             w_pop;
    logic             w_full;
    logic             w_overwrite;
    logic [PTR_W-1:0] w_wr_addr;
    logic [PTR_W-1:0] w_wr_next;
    logic [PTR_W-1:0] w_rd_next;
    logic [OCC_W-1:0] w_count_next;
    logic [7:0]       w_head_next;

    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tdata_o  = r_tdata;
    assign overflow_o      = r_overflow;

    // A commit is the last cycle of an unbroken window on a value differing from stable
    assign w_commit = (r_sync2 != r_stable) && (r_sync2 == r_cand) && (r_cnt == CNT_LAST);
    assign w_pop    = r_tvalid && m_axis_tready_i;

    // Two-flop synchronizer for the raw switch inputs
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_sync1 <= 8'h00;
            r_sync2 <= 8'h00;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: any bounce restarts the window, a full window commits the candidate
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            r_stable <= 8'h00;
            r_cand   <= 8'h00;
            r_cnt    <= {CNT_W{1'b0}};
        end else if (r_sync2 == r_stable) begin
            r_cand <= r_stable;
            r_cnt  <= {CNT_W{1'b0}};
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= {CNT_W{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_cand;
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // FIFO next state; the head is precomputed so tvalid/tdata can be registered
    always_comb begin
        w_full      = (r_count == OCC_FULL);
        w_overwrite = w_commit && w_full && !w_pop;

        if (w_overwrite) begin
            w_wr_addr = r_wr_ptr - PTR_ONE;
        end else begin
            w_wr_addr = r_wr_ptr;
        end

        if (w_commit && !w_overwrite) begin
            w_wr_next = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_next = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_next = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_next = r_rd_ptr;
        end

        if (w_commit && !w_pop && !w_full) begin
            w_count_next = r_count + OCC_ONE;
        end else if (w_pop && !w_commit) begin
            w_count_next = r_count - OCC_ONE;
        end else begin
            w_count_next = r_count;
        end

        // Overwrite targets tail-1, which can never be the head since depth >= 2
        if (w_commit && (w_wr_addr == w_rd_next)) begin
            w_head_next = r_cand;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    // FIFO storage, pointers, registered stream outputs and sticky overflow
    always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i) begin
        if (!axis_aresetn_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_count    <= {OCC_W{1'b0}};
            r_tvalid   <= 1'b0;
            r_tdata    <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            if (w_commit) begin
                r_mem[w_wr_addr] <= r_cand;
            end
            r_rd_ptr <= w_rd_next;
            r_wr_ptr <= w_wr_next;
            r_count  <= w_count_next;
            r_tvalid <= (w_count_next != {OCC_W{1'b0}});
            r_tdata  <= w_head_next;
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_axis.sv
// Directed bench for sw_axis: expected beats are queued as switch values are
// driven and popped by a monitor whenever the stream handshake completes.
module tb_sw_axis;

    localparam int DC = 4;
    localparam int FD = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] sw     = 8'h00;
    logic       tready = 1'b1;
    logic       tvalid;
    logic [7:0] tdata;
    logic       ovf;

    int         checks = 0;
    int         errors = 0;
    int         beats  = 0;
    int         b0;
    logic       acc;
    logic [7:0] exp_q[$];

    sw_axis #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
        .axis_aclk_i    (clk),
        .axis_aresetn_i (rst_n),
        .sw_i           (sw),
        .m_axis_tready_i(tready),
        .m_axis_tvalid_o(tvalid),
        .m_axis_tdata_o (tdata),
        .overflow_o     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic expect_beat);
        sw = v;
        if (expect_beat) exp_q.push_back(v);
    endtask

    // Monitor: inputs only change just after rising edges, so the falling edge sees the coming handshake
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            beats++;
            chk("beat_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("beat_data", 32'(tdata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        // Reset state
        tick(2);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Idle after reset
        acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            acc = acc | tvalid | ovf;
        end
        chk("idle_quiet", 32'(acc), 32'd0);

        // Single change with exact latency
        b0 = beats;
        drive(8'hA5, 1'b1);
        tick(6);
        chk("s2_not_early", 32'(tvalid), 32'd0);
        tick(1);
        chk("s2_tvalid", 32'(tvalid), 32'd1);
        chk("s2_tdata", 32'(tdata), 32'hA5);
        tick(1);
        chk("s2_tvalid_drops", 32'(tvalid), 32'd0);
        chk("s2_one_beat", 32'(beats - b0), 32'd1);

        // Return to 0x00 (itself one event)
        drive(8'h00, 1'b1);
        tick(12);
        chk("back_to_zero", 32'(exp_q.size()), 32'd0);

        // Bounce shorter than the window
        b0 = beats;
        drive(8'h01, 1'b0);
        tick(3);
        drive(8'h00, 1'b0);
        tick(12);
        chk("s3a_no_beat", 32'(beats - b0), 32'd0);

        // Bounce 0x01 -> 0x03, only 0x03 may appear
        b0 = beats;
        drive(8'h01, 1'b0);
        tick(2);
        drive(8'h03, 1'b1);
        tick(12);
        chk("s3b_one_beat", 32'(beats - b0), 32'd1);
        chk("s3b_drained", 32'(exp_q.size()), 32'd0);

        // Overflow: 0x04 is replaced by 0x05, head held at 0x01
        tready = 1'b0;
        b0 = beats;
        for (int v = 1; v <= 5; v++) begin
            drive(8'(v), (v != 4));
            tick(10);
            chk("s4_stall_tvalid", 32'(tvalid), 32'd1);
            chk("s4_stall_head", 32'(tdata), 32'h01);
            if (v == 4) chk("s4_no_ovf_yet", 32'(ovf), 32'd0);
        end
        chk("s4_ovf_set", 32'(ovf), 32'd1);
        tready = 1'b1;
        tick(4);
        chk("s4_drain_idle", 32'(tvalid), 32'd0);
        chk("s4_drain_beats", 32'(beats - b0), 32'd4);
        chk("s4_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("s4_ovf_sticky", 32'(ovf), 32'd1);

        // Clear overflow with a reset, switches at 0x00 so no snapshot event
        rst_n = 1'b0;
        drive(8'h00, 1'b0);
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        chk("rst2_ovf", 32'(ovf), 32'd0);

        // Push and pop together while full
        tready = 1'b0;
        for (int v = 6; v <= 9; v++) begin
            drive(8'(v), 1'b1);
            tick(10);
        end
        drive(8'h0A, 1'b1);
        tick(6);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        chk("s5_ovf_clear", 32'(ovf), 32'd0);
        chk("s5_tvalid", 32'(tvalid), 32'd1);
        chk("s5_new_head", 32'(tdata), 32'h07);
        chk("s5_pending", 32'(exp_q.size()), 32'd4);
        tready = 1'b1;
        tick(4);
        chk("s5_drain_idle", 32'(tvalid), 32'd0);
        chk("s5_drain_empty", 32'(exp_q.size()), 32'd0);
        chk("s5_ovf_still_clear", 32'(ovf), 32'd0);

        // Reset mid-operation with 3 queued entries and overflow set
        tready = 1'b0;
        drive(8'h11, 1'b1); tick(10);
        drive(8'h22, 1'b1); tick(10);
        drive(8'h33, 1'b1); tick(10);
        drive(8'h44, 1'b0); tick(10);
        drive(8'h55, 1'b1); tick(10);
        tready = 1'b1;
        tick(1);
        tready = 1'b0;
        chk("s6_pre_tvalid", 32'(tvalid), 32'd1);
        chk("s6_pre_ovf", 32'(ovf), 32'd1);
        chk("s6_pre_pending", 32'(exp_q.size()), 32'd3);
        rst_n = 1'b0;
        drive(8'h5A, 1'b0);
        exp_q.delete();
        #1;
        chk("s6_async_tvalid", 32'(tvalid), 32'd0);
        chk("s6_async_ovf", 32'(ovf), 32'd0);
        tready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        exp_q.push_back(8'h5A);
        b0 = beats;
        tick(6);
        chk("s6_not_early", 32'(tvalid), 32'd0);
        tick(1);
        chk("s6_tvalid", 32'(tvalid), 32'd1);
        chk("s6_tdata", 32'(tdata), 32'h5A);
        tick(1);
        chk("s6_tvalid_drops", 32'(tvalid), 32'd0);
        chk("s6_one_beat", 32'(beats - b0), 32'd1);
        chk("s6_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
